// File: rtl/sha256_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_pkg - shared SHA-256 types, widths and initial hash values.  Rev 1.0
// ----------------------------------------------------------------------------
package sha256_pkg;

  localparam int WORD_W        = 32;
  localparam int BLOCK_W       = 512;
  localparam int WORDS_PER_BLK = BLOCK_W / WORD_W;
  localparam int LEN_FIELD_W   = 64;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    S_FILL     = 2'd0,
    S_SEND     = 2'd1,
    S_SEND_PAD = 2'd2,
    S_FINAL    = 2'd3
  } pad_state_t;

  function automatic logic [WORD_W-1:0] iv_word(input logic [2:0] idx);
    logic [WORD_W-1:0] v;
    case (idx)
      3'd0:    v = 32'h6a09e667;
      3'd1:    v = 32'hbb67ae85;
      3'd2:    v = 32'h3c6ef372;
      3'd3:    v = 32'ha54ff53a;
      3'd4:    v = 32'h510e527f;
      3'd5:    v = 32'h9b05688c;
      3'd6:    v = 32'h1f83d9ab;
      default: v = 32'h5be0cd19;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_padder - word stream to padded 512-bit SHA-256 blocks.  Rev 1.0
// ----------------------------------------------------------------------------
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [2:0]          in_bytes,
  output logic                in_ready,
  output logic [BLOCK_W-1:0]  blk_data,
  output logic                blk_valid,
  output logic                blk_first,
  output logic                blk_last,
  input  logic                blk_ready
);

  pad_state_t              r_state;
  pad_state_t              w_state_next;
  logic [WORD_W-1:0]       r_buf [WORDS_PER_BLK];
  logic [3:0]              r_widx;
  logic [LEN_W-1:0]        r_bitcnt;
  logic                    r_first_pending;
  logic                    r_extra_term;

  logic                    w_in_ready;
  logic                    w_blk_valid;
  logic                    w_blk_last;
  logic                    w_accept;
  logic                    w_blk_hs;
  logic [2:0]              w_n;
  logic [6:0]              w_m;
  logic [LEN_W-1:0]        w_bitcnt_next;
  logic [LEN_FIELD_W-1:0]  w_len_now;
  logic [LEN_FIELD_W-1:0]  w_len_reg;
  logic [BLOCK_W-1:0]      w_blk_data;

  // Keeps the first n bytes of w, drops the terminator right after them.
  function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] w,
                                                 input logic [2:0] n);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < n)       r[WORD_W-1-8*b -: 8] = w[WORD_W-1-8*b -: 8];
      else if (3'(b) == n) r[WORD_W-1-8*b -: 8] = PAD_BYTE;
    end
    return r;
  endfunction

  assign w_n           = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign w_m           = {1'b0, r_widx, 2'b00} + {4'b0000, w_n};
  assign w_accept      = in_valid && w_in_ready;
  assign w_blk_hs      = w_blk_valid && blk_ready;
  assign w_bitcnt_next = r_bitcnt + (in_last ? (LEN_W'(w_n) << 3) : LEN_W'(WORD_W));
  assign w_len_now     = LEN_FIELD_W'(w_bitcnt_next);
  assign w_len_reg     = LEN_FIELD_W'(r_bitcnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_blk_valid  = 1'b0;
    w_blk_last   = 1'b0;
    case (r_state)
      S_FILL: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          if (in_last)              w_state_next = (w_m <= 7'd55) ? S_FINAL : S_SEND_PAD;
          else if (r_widx == 4'd15) w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        w_blk_valid = 1'b1;
        if (blk_ready) w_state_next = S_FILL;
      end
      S_SEND_PAD: begin
        w_blk_valid = 1'b1;
        if (blk_ready) w_state_next = S_FINAL;
      end
      S_FINAL: begin
        w_blk_valid = 1'b1;
        w_blk_last  = 1'b1;
        if (blk_ready) w_state_next = S_FILL;
      end
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS_PER_BLK; i++) r_buf[i] <= '0;
      r_widx          <= '0;
      r_bitcnt        <= '0;
      r_first_pending <= 1'b1;
      r_extra_term    <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_bitcnt <= w_bitcnt_next;
            if (!in_last) begin
              r_buf[r_widx] <= in_data;
              if (r_widx != 4'd15) r_widx <= r_widx + 4'd1;
            end else begin
              r_buf[r_widx] <= pad_word(in_data, w_n);
              // A full final word pushes the terminator into the next slot.
              if (w_n == 3'd4 && r_widx != 4'd15) r_buf[r_widx + 4'd1] <= {PAD_BYTE, 24'h0};
              r_extra_term <= (w_m == 7'd64);
              if (w_m <= 7'd55) begin
                r_buf[14] <= w_len_now[LEN_FIELD_W-1 -: WORD_W];
                r_buf[15] <= w_len_now[WORD_W-1:0];
              end
            end
          end
        end
        S_SEND: begin
          if (w_blk_hs) begin
            for (int i = 0; i < WORDS_PER_BLK; i++) r_buf[i] <= '0;
            r_widx          <= '0;
            r_first_pending <= 1'b0;
          end
        end
        S_SEND_PAD: begin
          if (w_blk_hs) begin
            for (int i = 0; i < WORDS_PER_BLK; i++) r_buf[i] <= '0;
            r_buf[0]        <= r_extra_term ? {PAD_BYTE, 24'h0} : '0;
            r_buf[14]       <= w_len_reg[LEN_FIELD_W-1 -: WORD_W];
            r_buf[15]       <= w_len_reg[WORD_W-1:0];
            r_widx          <= '0;
            r_first_pending <= 1'b0;
          end
        end
        S_FINAL: begin
          if (w_blk_hs) begin
            for (int i = 0; i < WORDS_PER_BLK; i++) r_buf[i] <= '0;
            r_widx          <= '0;
            r_bitcnt        <= '0;
            r_first_pending <= 1'b1;
          end
        end
        default: r_widx <= '0;
      endcase
    end
  end

  always_comb begin
    w_blk_data = '0;
    for (int i = 0; i < WORDS_PER_BLK; i++)
      w_blk_data[BLOCK_W-1-WORD_W*i -: WORD_W] = r_buf[i];
  end

  // in_ready is held low while reset is asserted so every output reads 0.
  assign in_ready  = w_in_ready && !reset;
  assign blk_valid = w_blk_valid;
  assign blk_last  = w_blk_last;
  assign blk_first = w_blk_valid && r_first_pending;
  assign blk_data  = w_blk_data;

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sha256_padder - random messages against a byte-level padding model.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_sha256_padder;

  typedef byte unsigned u8;
  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  logic         clk;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready;

  int   n_checks = 0;
  int   n_fail   = 0;
  blk_t exp_q[$];
  logic mon_en;
  int   bp_mode;

  sha256_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: message bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic expect_msg(input u8 msg[$]);
    u8           p[$];
    logic [63:0] bits;
    blk_t        b;
    int          nb;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int k = 0; k < nb; k++) begin
      b.d = '0;
      for (int j = 0; j < 64; j++) b.d[511-8*j -: 8] = p[64*k+j];
      b.f = (k == 0);
      b.l = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_word(input logic [31:0] d, input logic lst, input logic [2:0] nb);
    logic acc;
    int   idle;
    acc  = 1'b0;
    idle = (bp_mode == 0) ? int'($urandom_range(0, 2)) : 0;
    repeat (idle) begin @(posedge clk); #1; end
    in_data  = d;
    in_valid = 1'b1;
    in_last  = lst;
    in_bytes = nb;
    for (int c = 0; c < 3000 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    if (!acc) chk_val("accept_timeout", in_ready, 1);
  endtask

  task automatic send_msg(input u8 msg[$]);
    int          len;
    int          nw;
    logic [31:0] d;
    logic        lst;
    logic [2:0]  nb;
    len = msg.size();
    nw  = (len == 0) ? 1 : (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = $urandom;
      for (int k = 0; k < 4; k++)
        if (4*w + k < len) d[31-8*k -: 8] = msg[4*w+k];
      lst = (w == nw - 1);
      nb  = lst ? 3'(len - 4*w) : 3'($urandom_range(0, 7));
      if (lst && nb == 3'd4 && $urandom_range(0, 1) == 1) nb = 3'($urandom_range(4, 7));
      drive_word(d, lst, nb);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk_val("drain_blocks_left", 512'(exp_q.size()), 512'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input u8 msg[$]);
    expect_msg(msg);
    send_msg(msg);
    drain();
  endtask

  task automatic rand_msg(input int len, output u8 m[$]);
    m.delete();
    repeat (len) m.push_back(8'($urandom));
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk_val({tag, "_blk_valid"}, blk_valid, 0);
    chk_val({tag, "_blk_data"},  blk_data,  0);
    chk_val({tag, "_blk_first"}, blk_first, 0);
    chk_val({tag, "_blk_last"},  blk_last,  0);
    chk_val({tag, "_in_ready"},  in_ready,  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Block monitor: picks blk_ready, checks hold stability and the model.
  logic         prev_stall;
  logic [511:0] prev_d;
  logic         prev_f;
  logic         prev_l;
  int           wait_cnt;
  logic         go;
  blk_t         e;

  initial begin
    blk_ready  = 1'b0;
    prev_stall = 1'b0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        blk_ready  = 1'b0;
        prev_stall = 1'b0;
        wait_cnt   = 0;
        continue;
      end
      if (prev_stall) begin
        chk_val("hold_valid", blk_valid, 1);
        chk_val("hold_data",  blk_data,  prev_d);
        chk_val("hold_first", blk_first, prev_f);
        chk_val("hold_last",  blk_last,  prev_l);
      end
      if (blk_valid) begin
        chk_val("in_ready_busy", in_ready, 0);
        go = (bp_mode == 1) ? (wait_cnt >= 10) : ($urandom_range(0, 2) == 0);
        if (go) begin
          if (exp_q.size() == 0) begin
            chk_val("unexpected_block", blk_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk_val("blk_data",  blk_data,  e.d);
            chk_val("blk_first", blk_first, e.f);
            chk_val("blk_last",  blk_last,  e.l);
          end
          blk_ready  = 1'b1;
          prev_stall = 1'b0;
          wait_cnt   = 0;
        end else begin
          blk_ready  = 1'b0;
          prev_stall = 1'b1;
          prev_d     = blk_data;
          prev_f     = blk_first;
          prev_l     = blk_last;
          wait_cnt++;
        end
      end else begin
        blk_ready  = 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  u8 m[$];
  u8 abc[$];

  initial begin
    reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = '0;
    mon_en   = 1'b0;
    bp_mode  = 0;
    abc = '{8'h61, 8'h62, 8'h63};

    #2;
    chk_val("rst_blk_valid", blk_valid, 0);
    chk_val("rst_blk_data",  blk_data,  0);
    chk_val("rst_blk_first", blk_first, 0);
    chk_val("rst_blk_last",  blk_last,  0);
    chk_val("rst_in_ready",  in_ready,  0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk_val("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    run_msg(abc);
    m.delete();
    run_msg(m);
    rand_msg(56, m); run_msg(m);
    rand_msg(64, m); run_msg(m);
    rand_msg(55, m); run_msg(m);

    bp_mode = 1;
    rand_msg(60, m);  run_msg(m);
    rand_msg(64, m);  run_msg(m);
    rand_msg(130, m); run_msg(m);
    bp_mode = 0;

    // Reset with seven words already buffered.
    for (int i = 0; i < 7; i++) drive_word($urandom, 1'b0, 3'($urandom_range(0, 7)));
    mon_en = 1'b0;
    async_reset("rst_fill");
    run_msg(abc);

    // Reset while the first of two blocks waits in the pad-send state.
    mon_en = 1'b0;
    rand_msg(60, m);
    send_msg(m);
    @(negedge clk);
    chk_val("pad_wait_valid", blk_valid, 1);
    chk_val("pad_wait_last",  blk_last,  0);
    chk_val("pad_wait_first", blk_first, 1);
    chk_val("pad_wait_inrdy", in_ready,  0);
    async_reset("rst_pad");
    run_msg(abc);

    for (int t = 0; t < 30; t++) begin
      rand_msg(int'($urandom_range(0, 140)), m);
      run_msg(m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
